// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   state_e      : converter FSM states (IDLE / SHIFT / DONE)
//   DIGIT_*      : per-digit constants used by the shift-and-add-3 step
//   add3_if_ge5  : one double-dabble digit adjustment
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_THRESH = 4'd5;
    localparam logic [3:0] DIGIT_ADJ    = 4'd3;
    localparam logic [3:0] DIGIT_SAT    = 4'd9;

    // A digit >= 5 becomes >= 10 after the next left shift, so pre-adding 3
    // makes the shift carry into the next decimal digit instead.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= DIGIT_THRESH) ? (d + DIGIT_ADJ) : d;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration.
//   acc_in    : current BCD accumulator (4*DIGITS bits, digit 0 in [3:0])
//   bit_in    : next magnitude bit (MSB first) shifted into the units digit
//   acc_out   : adjusted and left-shifted accumulator
//   carry_out : 1 when the top digit spills out of the accumulator
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] acc_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] acc_out,
    output logic                carry_out
);

    localparam int AW = 4 * DIGITS;

    // Top-digit values that wrap past 4 bits when 3 is added. They only occur
    // once an overflow has already happened, but are flagged for robustness.
    localparam logic [3:0] DIGIT_WRAP = 4'd13;

    logic [AW-1:0] adj;

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = add3_if_ge5(acc_in[4*i +: 4]);
        end
    end

    assign acc_out   = {adj[AW-2:0], bit_in};
    assign carry_out = adj[AW-1] | (acc_in[AW-1 -: 4] >= DIGIT_WRAP);

endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Parameters: BIN_WIDTH (input width), DIGITS (BCD digits), SIGNED (1 =
// two's-complement input, sign + magnitude output).
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, bin_in captured when both high
//   out_valid/out_ready  : output handshake, result retired when both high
//   bcd_out              : packed BCD result, digit 0 in [3:0]
//   sign_out             : 1 = negative input
//   overflow             : magnitude did not fit, bcd_out saturated to all 9s
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge. in_ready is high
// only in IDLE; out_valid is high only in DONE, where outputs are held.
module bin_bcd_conv
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*DIGITS-1:0]  bcd_out,
    output logic                 sign_out,
    output logic                 overflow
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int AW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST_ITER = CW'(BIN_WIDTH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [BIN_WIDTH-1:0] mag_q, mag_d;
    logic                 neg_q, neg_d;
    logic                 sticky_q, sticky_d;
    logic [AW-1:0]        bcd_q, bcd_d;
    logic                 sign_q, sign_d;
    logic                 ovf_q, ovf_d;

    logic [AW-1:0]        step_acc;
    logic                 step_carry;

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .acc_in    (acc_q),
        .bit_in    (mag_q[BIN_WIDTH-1]),
        .acc_out   (step_acc),
        .carry_out (step_carry)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Negating the most negative value wraps to 2^(W-1),
                    // which is the correct unsigned magnitude.
                    if ((SIGNED != 0) && bin_in[BIN_WIDTH-1]) begin
                        mag_d = -bin_in;
                        neg_d = 1'b1;
                    end else begin
                        mag_d = bin_in;
                        neg_d = 1'b0;
                    end
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d    = step_acc;
                mag_d    = mag_q << 1;
                sticky_d = sticky_q | step_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Result registers load only here, so they stay put
                    // through the whole next conversion.
                    state_d = DONE;
                    bcd_d   = (sticky_q | step_carry) ? {DIGITS{DIGIT_SAT}} : step_acc;
                    ovf_d   = sticky_q | step_carry;
                    sign_d  = neg_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            neg_q    <= neg_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign sign_out  = sign_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin_bcd_conv.sv
// Bench for bin_bcd_conv: four parameterisations share one clock and one
// stimulus bus; sel picks which instance sees in_valid and whose outputs
// are observed.
//   0: defaults (8-bit, 3 digits, unsigned)
//   1: 8-bit, 3 digits, signed
//   2: 8-bit, 2 digits, unsigned (overflow cases)
//   3: 16-bit, 5 digits, unsigned
module tb_bin_bcd_conv;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        in_valid;
    logic        out_ready;
    logic [15:0] bin_in;
    int          sel;

    logic iv0, iv1, iv2, iv3;
    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);
    assign iv3 = in_valid && (sel == 3);

    logic        rdy0, rdy1, rdy2, rdy3;
    logic        ov0, ov1, ov2, ov3;
    logic [11:0] bcd0, bcd1;
    logic [7:0]  bcd2;
    logic [19:0] bcd3;
    logic        sg0, sg1, sg2, sg3;
    logic        of0, of1, of2, of3;

    bin_bcd_conv #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(rdy0),
        .bin_in(bin_in[7:0]), .out_valid(ov0), .out_ready(out_ready),
        .bcd_out(bcd0), .sign_out(sg0), .overflow(of0)
    );
    bin_bcd_conv #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(rdy1),
        .bin_in(bin_in[7:0]), .out_valid(ov1), .out_ready(out_ready),
        .bcd_out(bcd1), .sign_out(sg1), .overflow(of1)
    );
    bin_bcd_conv #(.BIN_WIDTH(8), .DIGITS(2), .SIGNED(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(rdy2),
        .bin_in(bin_in[7:0]), .out_valid(ov2), .out_ready(out_ready),
        .bcd_out(bcd2), .sign_out(sg2), .overflow(of2)
    );
    bin_bcd_conv #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_ready(rdy3),
        .bin_in(bin_in), .out_valid(ov3), .out_ready(out_ready),
        .bcd_out(bcd3), .sign_out(sg3), .overflow(of3)
    );

    // ---------------- observed-output mux ----------------
    logic        m_in_ready, m_out_valid, m_sign, m_ovf;
    logic [19:0] m_bcd;

    always_comb begin
        m_in_ready  = rdy0;
        m_out_valid = ov0;
        m_bcd       = {8'd0, bcd0};
        m_sign      = sg0;
        m_ovf       = of0;
        case (sel)
            1: begin
                m_in_ready = rdy1; m_out_valid = ov1; m_bcd = {8'd0, bcd1};
                m_sign = sg1; m_ovf = of1;
            end
            2: begin
                m_in_ready = rdy2; m_out_valid = ov2; m_bcd = {12'd0, bcd2};
                m_sign = sg2; m_ovf = of2;
            end
            3: begin
                m_in_ready = rdy3; m_out_valid = ov3; m_bcd = bcd3;
                m_sign = sg3; m_ovf = of3;
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- driver ----------------
    // Presents v to instance s after `gap` idle cycles, waits for the result
    // (out_ready assumed high) and retires it. lat = edges from acceptance to
    // out_valid, -1 on timeout. saw_ready flags in_ready seen while busy.
    task automatic convert(input int s, input logic [15:0] v, input int gap,
                           output logic [19:0] r_bcd, output logic r_sign,
                           output logic r_ovf, output int lat, output logic saw_ready);
        int w;
        sel = s;
        repeat (gap) @(posedge clk);
        #1;
        bin_in   = v;
        in_valid = 1'b1;
        @(negedge clk);
        w = 0;
        while (!m_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        bin_in    = 16'($urandom);
        lat       = -1;
        saw_ready = 1'b0;
        r_bcd     = '0;
        r_sign    = 1'b0;
        r_ovf     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_out_valid) begin
                lat    = c;
                r_bcd  = m_bcd;
                r_sign = m_sign;
                r_ovf  = m_ovf;
                break;
            end
            if (m_in_ready) saw_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          sel;
        logic [15:0] val;
        logic [19:0] exp_bcd;
        logic        exp_sign;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[19];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [19:0] r_bcd;
        logic        r_sign, r_ovf, saw_ready, saw_valid;
        int          lat;
        string       nm;

        vecs[0]  = '{0, 16'd100,   20'h00100, 1'b0, 1'b0, 8};
        vecs[1]  = '{0, 16'd0,     20'h00000, 1'b0, 1'b0, 8};
        vecs[2]  = '{0, 16'd255,   20'h00255, 1'b0, 1'b0, 8};
        vecs[3]  = '{0, 16'd9,     20'h00009, 1'b0, 1'b0, 8};
        vecs[4]  = '{0, 16'd10,    20'h00010, 1'b0, 1'b0, 8};
        vecs[5]  = '{0, 16'd199,   20'h00199, 1'b0, 1'b0, 8};
        vecs[6]  = '{1, 16'h0080,  20'h00128, 1'b1, 1'b0, 8};
        vecs[7]  = '{1, 16'h00FF,  20'h00001, 1'b1, 1'b0, 8};
        vecs[8]  = '{1, 16'h0000,  20'h00000, 1'b0, 1'b0, 8};
        vecs[9]  = '{1, 16'h007F,  20'h00127, 1'b0, 1'b0, 8};
        vecs[10] = '{1, 16'h009C,  20'h00100, 1'b1, 1'b0, 8};
        vecs[11] = '{2, 16'd200,   20'h00099, 1'b0, 1'b1, 8};
        vecs[12] = '{2, 16'd99,    20'h00099, 1'b0, 1'b0, 8};
        vecs[13] = '{2, 16'd100,   20'h00099, 1'b0, 1'b1, 8};
        vecs[14] = '{2, 16'd0,     20'h00000, 1'b0, 1'b0, 8};
        vecs[15] = '{2, 16'd42,    20'h00042, 1'b0, 1'b0, 8};
        vecs[16] = '{3, 16'd65535, 20'h65535, 1'b0, 1'b0, 16};
        vecs[17] = '{3, 16'd12345, 20'h12345, 1'b0, 1'b0, 16};
        vecs[18] = '{3, 16'd0,     20'h00000, 1'b0, 1'b0, 16};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bin_in    = '0;
        sel       = 0;

        // ---- reset state, every instance ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check($sformatf("reset_in_ready[%0d]", s), 32'(m_in_ready), 32'd1);
            check($sformatf("reset_out_valid[%0d]", s), 32'(m_out_valid), 32'd0);
            check($sformatf("reset_bcd[%0d]", s), 32'(m_bcd), 32'd0);
            check($sformatf("reset_sign[%0d]", s), 32'(m_sign), 32'd0);
            check($sformatf("reset_ovf[%0d]", s), 32'(m_ovf), 32'd0);
        end
        reset_n = 1'b1;
        sel     = 0;
        @(posedge clk);
        #1;

        // ---- directed table ----
        for (int i = 0; i < 19; i++) begin
            convert(vecs[i].sel, vecs[i].val, 1, r_bcd, r_sign, r_ovf, lat, saw_ready);
            nm = $sformatf("vec%0d_sel%0d_val%0d", i, vecs[i].sel, vecs[i].val);
            check({nm, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({nm, "_bcd"}, 32'(r_bcd), 32'(vecs[i].exp_bcd));
            check({nm, "_sign"}, 32'(r_sign), 32'(vecs[i].exp_sign));
            check({nm, "_ovf"}, 32'(r_ovf), 32'(vecs[i].exp_ovf));
            check({nm, "_in_ready_busy"}, 32'(saw_ready), 32'd0);
        end

        // ---- full 8-bit sweep with random idle gaps ----
        for (int v = 0; v < 256; v++) begin
            exp_q.push_back(to_bcd(v));
            convert(0, 16'(v), $urandom_range(0, 3), r_bcd, r_sign, r_ovf, lat, saw_ready);
            check($sformatf("sweep_%0d_bcd", v), 32'(r_bcd), 32'(exp_q.pop_front()));
            check($sformatf("sweep_%0d_busy", v), {31'd0, saw_ready} | 32'(lat != 8), 32'd0);
        end

        // ---- backpressure: result held, new input waits for handshake ----
        sel       = 0;
        out_ready = 1'b0;
        @(negedge clk);
        bin_in   = 16'd42;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        bin_in = 16'd77;
        saw_valid = 1'b0;
        for (int c = 0; c < 20 && !saw_valid; c++) begin
            @(negedge clk);
            saw_valid = m_out_valid;
        end
        check("bp_out_valid_seen", 32'(saw_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 32'(m_out_valid), 32'd1);
            check($sformatf("bp_hold%0d_bcd", c), 32'(m_bcd), 32'h042);
            check($sformatf("bp_hold%0d_in_ready", c), 32'(m_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_hs_out_valid", 32'(m_out_valid), 32'd0);
        check("bp_after_hs_in_ready", 32'(m_in_ready), 32'd1);
        check("bp_after_hs_bcd_held", 32'(m_bcd), 32'h042);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_out_valid) begin
                lat = c;
                break;
            end
        end
        check("bp_second_latency", 32'(lat), 32'd8);
        check("bp_second_bcd", 32'(m_bcd), 32'h077);
        @(posedge clk);
        #1;

        // ---- reset in the middle of a 16-bit conversion ----
        sel = 3;
        @(negedge clk);
        bin_in   = 16'd50000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_in_ready", 32'(m_in_ready), 32'd1);
        check("midreset_out_valid", 32'(m_out_valid), 32'd0);
        reset_n   = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (m_out_valid) saw_valid = 1'b1;
        end
        check("midreset_no_output", 32'(saw_valid), 32'd0);
        convert(3, 16'd40000, 0, r_bcd, r_sign, r_ovf, lat, saw_ready);
        check("post_reset_latency", 32'(lat), 32'd16);
        check("post_reset_bcd", 32'(r_bcd), 32'h40000);
        check("post_reset_ovf", 32'(r_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
